// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the sdram arbiter slice.
// Grant encoding, FSM states and default bus widths.
package sdram_arb_pkg;

  localparam int ARB_AW = 25;
  localparam int ARB_DW = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DIO  = 2'd1,
    GNT_VID  = 2'd2,
    GNT_CPU  = 2'd3
  } grant_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester + sdram port bundle for sdram_arbiter.
// slave: arbiter side; master: requesters/sdram side.
import sdram_arb_pkg::*;

interface sdram_arbiter_if #(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
);
  logic          slot_start;
  logic          dio_wr;
  logic [AW-1:0] dio_addr;
  logic [DW-1:0] dio_data;
  logic          dio_ovf;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          vid_ack;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_din;
  logic          sd_we;
  logic          sd_oe;
  logic [DW-1:0] sd_dout;
  logic [1:0]    grant;

  modport slave (
    input  slot_start, dio_wr, dio_addr, dio_data,
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  sd_dout,
    output dio_ovf, vid_rdata, vid_ack,
    output cpu_rdata, cpu_ack,
    output sd_addr, sd_din, sd_we, sd_oe, grant
  );

  modport master (
    output slot_start, dio_wr, dio_addr, dio_data,
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output sd_dout,
    input  dio_ovf, vid_rdata, vid_ack,
    input  cpu_rdata, cpu_ack,
    input  sd_addr, sd_din, sd_we, sd_oe, grant
  );

endinterface

// File: rtl/sdram_arbiter_prio.sv
// Winner select for one sdram slot: dio > vid > cpu.
// In: dio_pend, vid_req, cpu_req, force_cpu. Out: win.
import sdram_arb_pkg::*;

module sdram_arb_prio (
  input  logic   dio_pend,
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   force_cpu,
  output grant_t win
);

  logic cpu_first;

  // force_cpu lets a waiting cpu jump ahead of video
  assign cpu_first = force_cpu && cpu_req;

  always_comb begin
    win = GNT_NONE;
    unique case (1'b1)
      dio_pend:
        win = GNT_DIO;
      (!dio_pend && vid_req && !cpu_first):
        win = GNT_VID;
      (!dio_pend && cpu_req && (cpu_first || !vid_req)):
        win = GNT_CPU;
      default:
        win = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram slot arbiter for dio download, video fetch and cpu.
// Ports: clk, reset (async, high), bus (sdram_arbiter_if.slave).
// Option: SDRAM_ARB_FAIR_EN bounds consecutive video grants.
import sdram_arb_pkg::*;

module sdram_arbiter #(
  parameter int AW          = ARB_AW,
  parameter int DW          = ARB_DW,
  parameter int SLOT_CYCLES = 8,
  parameter int RD_LAT      = 5
`ifdef SDRAM_ARB_FAIR_EN
  ,
  parameter int MAX_VID_RUN = 4
`endif
) (
  input  logic           clk,
  input  logic           reset,
  sdram_arbiter_if.slave bus
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_RD  = CW'(RD_LAT);
  localparam logic [CW-1:0] CNT_END = CW'(SLOT_CYCLES - 2);

  state_t        state;
  logic [CW-1:0] cnt;
  grant_t        owner;
  grant_t        win;
  logic          pick;
  logic          force_cpu;

  logic [AW-1:0] sd_addr_q;
  logic [DW-1:0] sd_din_q;
  logic          sd_we_q;
  logic          sd_oe_q;
  logic [DW-1:0] vid_rdata_q;
  logic [DW-1:0] cpu_rdata_q;
  logic          vid_ack_q;
  logic          cpu_ack_q;

  logic          dio_pend;
  logic [AW-1:0] dio_addr_q;
  logic [DW-1:0] dio_data_q;
  logic          dio_ovf_q;
  logic          dio_take;

  sdram_arb_prio u_prio (
    .dio_pend  (dio_pend),
    .vid_req   (bus.vid_req),
    .cpu_req   (bus.cpu_req),
    .force_cpu (force_cpu),
    .win       (win)
  );

  assign pick = (state == IDLE) && bus.slot_start
             && (win != GNT_NONE);

  // holding register is released when its write completes
  assign dio_take = (state == ACCESS) && (owner == GNT_DIO)
                 && (cnt == CNT_RD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dio_pend   <= 1'b0;
      dio_addr_q <= '0;
      dio_data_q <= '0;
      dio_ovf_q  <= 1'b0;
    end else begin
      if (dio_take) dio_pend <= 1'b0;
      if (bus.dio_wr) begin
        if (!dio_pend || dio_take) begin
          dio_pend   <= 1'b1;
          dio_addr_q <= bus.dio_addr;
          dio_data_q <= bus.dio_data;
        end else begin
          dio_ovf_q <= 1'b1;
        end
      end
    end
  end

`ifdef SDRAM_ARB_FAIR_EN
  localparam int RW = $clog2(MAX_VID_RUN + 1);

  logic [RW-1:0] vid_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_run <= '0;
    end else if (!bus.cpu_req) begin
      vid_run <= '0;
    end else if (pick) begin
      vid_run <= (win == GNT_VID) ? vid_run + 1'b1 : '0;
    end
  end

  assign force_cpu = (vid_run == RW'(MAX_VID_RUN));
`else
  assign force_cpu = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= GNT_NONE;
      sd_addr_q   <= '0;
      sd_din_q    <= '0;
      sd_we_q     <= 1'b0;
      sd_oe_q     <= 1'b0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
    end else begin
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick) begin
            state <= ACCESS;
            cnt   <= '0;
            owner <= win;
            unique case (win)
              GNT_DIO: begin
                sd_addr_q <= dio_addr_q;
                sd_din_q  <= dio_data_q;
                sd_we_q   <= 1'b1;
                sd_oe_q   <= 1'b0;
              end
              GNT_VID: begin
                sd_addr_q <= bus.vid_addr;
                sd_we_q   <= 1'b0;
                sd_oe_q   <= 1'b1;
              end
              GNT_CPU: begin
                sd_addr_q <= bus.cpu_addr;
                sd_din_q  <= bus.cpu_wdata;
                sd_we_q   <= bus.cpu_we;
                sd_oe_q   <= !bus.cpu_we;
              end
              default: ;
            endcase
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_RD) begin
            unique case (owner)
              GNT_VID: begin
                vid_rdata_q <= bus.sd_dout;
                vid_ack_q   <= 1'b1;
              end
              GNT_CPU: begin
                if (!sd_we_q) cpu_rdata_q <= bus.sd_dout;
                cpu_ack_q <= 1'b1;
              end
              default: ;
            endcase
          end
          if (cnt == CNT_END) begin
            state   <= IDLE;
            cnt     <= '0;
            owner   <= GNT_NONE;
            sd_we_q <= 1'b0;
            sd_oe_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sd_addr   = sd_addr_q;
  assign bus.sd_din    = sd_din_q;
  assign bus.sd_we     = sd_we_q;
  assign bus.sd_oe     = sd_oe_q;
  assign bus.grant     = owner;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dio_ovf   = dio_ovf_q;

endmodule
